stage3_bus_arbiter: RTL

STAGE3_BUS_ARBITER -- requirements
Module: stage3_bus_arbiter

---
 rtl/stage3_bus_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/stage3_bus_arbiter.sv
// Two-master bus arbiter: merges an instruction-fetch port and a data port
// onto one shared generic bus. Data normally wins arbitration. A starvation
// counter hands the bus to fetch after STARVE_LIMIT data grants in a row.
module stage3_bus_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  // fetch port
  input  logic [31:0] i_addr,
  input  logic        i_ren,
  output logic [31:0] i_rdata,
  output logic        i_busy,
  // data port
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic        d_ren,
  input  logic        d_wen,
  input  logic [3:0]  d_byte_en,
  output logic [31:0] d_rdata,
  output logic        d_busy,
  // shared bus
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic        m_ren,
  output logic        m_wen,
  output logic [3:0]  m_byte_en,
  input  logic [31:0] m_rdata,
  input  logic        m_busy
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_I = 2'd1;
  localparam logic [1:0] GNT_D = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       byte_en_q, byte_en_d;
  logic             ren_q, ren_d;
  logic             wen_q, wen_d;

  logic d_req;
  logic fetch_win;
  logic i_done;
  logic d_done;

  // Next-state logic: arbitration in IDLE, grant latching, completion back to IDLE
  always_comb begin
    d_req        = d_ren | d_wen;
    fetch_win    = i_ren & (~d_req | (starve_cnt_q == LIMIT_C));
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    byte_en_d    = byte_en_q;
    ren_d        = ren_q;
    wen_d        = wen_q;
    case (state_q)
      IDLE: begin
        if (fetch_win) begin
          state_d      = GNT_I;
          addr_d       = i_addr;
          wdata_d      = 32'h0;
          byte_en_d    = 4'b1111;
          ren_d        = 1'b1;
          wen_d        = 1'b0;
          starve_cnt_d = '0;
        end else if (d_req) begin
          state_d   = GNT_D;
          addr_d    = d_addr;
          wdata_d   = d_wdata;
          byte_en_d = d_byte_en;
          ren_d     = d_ren;
          wen_d     = d_wen;
          if (i_ren) begin
            if (starve_cnt_q != LIMIT_C) starve_cnt_d = starve_cnt_q + CNT_W'(1);
          end else begin
            starve_cnt_d = '0;
          end
        end else begin
          starve_cnt_d = '0;
        end
      end
      GNT_I, GNT_D: begin
        if (!m_busy) begin
          state_d = IDLE;
          ren_d   = 1'b0;
          wen_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        ren_d   = 1'b0;
        wen_d   = 1'b0;
      end
    endcase
  end

  // State and latch registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      byte_en_q    <= 4'h0;
      ren_q        <= 1'b0;
      wen_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      byte_en_q    <= byte_en_d;
      ren_q        <= ren_d;
      wen_q        <= wen_d;
    end
  end

  // Requester responses: busy drops and read data passes only on owner completion
  always_comb begin
    i_done    = (state_q == GNT_I) & ~m_busy;
    d_done    = (state_q == GNT_D) & ~m_busy;
    i_busy    = i_ren & ~i_done;
    d_busy    = (d_ren | d_wen) & ~d_done;
    i_rdata   = (i_done & i_ren) ? m_rdata : 32'h0;
    d_rdata   = (d_done & (d_ren | d_wen)) ? m_rdata : 32'h0;
    m_addr    = addr_q;
    m_wdata   = wdata_q;
    m_byte_en = byte_en_q;
    m_ren     = ren_q;
    m_wen     = wen_q;
  end

endmodule
